// File: rtl/bram_port_arbiter_if.sv
// Bundle of the CPU port, host port and BRAM data port seen by bram_port_arbiter.
// slave is the arbiter's view; master is the surrounding CPU/host/BRAM environment.
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int WE_WIDTH = DATA_WIDTH / 8;

    logic                  c_req;
    logic [WE_WIDTH-1:0]   c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_gnt;
    logic                  c_rvalid;
    logic [DATA_WIDTH-1:0] c_rdata;

    logic                  h_req;
    logic [WE_WIDTH-1:0]   h_we;
    logic [ADDR_WIDTH-1:0] h_addr;
    logic [DATA_WIDTH-1:0] h_wdata;
    logic                  h_lock;
    logic                  h_gnt;
    logic                  h_rvalid;
    logic [DATA_WIDTH-1:0] h_rdata;

    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [WE_WIDTH-1:0]   bram_we;
    logic [DATA_WIDTH-1:0] bram_din;
    logic [DATA_WIDTH-1:0] bram_dout;

    logic                  locked;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  h_req, h_we, h_addr, h_wdata, h_lock,
        output h_gnt, h_rvalid, h_rdata,
        output bram_addr, bram_we, bram_din,
        input  bram_dout,
        output locked
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output h_req, h_we, h_addr, h_wdata, h_lock,
        input  h_gnt, h_rvalid, h_rdata,
        input  bram_addr, bram_we, bram_din,
        output bram_dout,
        input  locked
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between CPU and host: CPU priority, host starvation guard, host lock.
// Grant is combinational (0 cycles), read data returns 1 cycle after grant; losers simply hold their request.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bram_port_arbiter_if.slave   bus
);
    localparam int WE_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_c_rvalid;
    logic              r_h_rvalid;

    logic                  w_c_gnt;
    logic                  w_h_gnt;
    logic                  w_starved;
    logic [ADDR_WIDTH-1:0] w_bram_addr;
    logic [WE_WIDTH-1:0]   w_bram_we;
    logic [DATA_WIDTH-1:0] w_bram_din;

    assign w_starved = (r_starve_cnt == CNT_MAX);

    // Reset gates the grants so nothing reaches the BRAM while rst_n is low.
    always_comb begin
        w_c_gnt = 1'b0;
        w_h_gnt = 1'b0;
        if (rst_n) begin
            if (r_state == LOCKED) begin
                w_h_gnt = bus.h_req;
            end else if (bus.h_req && w_starved) begin
                w_h_gnt = 1'b1;
            end else if (bus.c_req) begin
                w_c_gnt = 1'b1;
            end else if (bus.h_req) begin
                w_h_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_bram_addr = '0;
        w_bram_we   = '0;
        w_bram_din  = '0;
        if (w_c_gnt) begin
            w_bram_addr = bus.c_addr;
            w_bram_we   = bus.c_we;
            w_bram_din  = bus.c_wdata;
        end else if (w_h_gnt) begin
            w_bram_addr = bus.h_addr;
            w_bram_we   = bus.h_we;
            w_bram_din  = bus.h_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= OPEN;
            r_starve_cnt <= '0;
            r_c_rvalid   <= 1'b0;
            r_h_rvalid   <= 1'b0;
        end else begin
            case (r_state)
                OPEN:    if (w_h_gnt && bus.h_lock) r_state <= LOCKED;
                LOCKED:  if (!bus.h_lock)           r_state <= OPEN;
                default:                            r_state <= OPEN;
            endcase

            // Counts only cycles where the host asked and lost; saturates at the limit.
            if (w_h_gnt || !bus.h_req) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            r_c_rvalid <= w_c_gnt && (bus.c_we == '0);
            r_h_rvalid <= w_h_gnt && (bus.h_we == '0);
        end
    end

    assign bus.c_gnt     = w_c_gnt;
    assign bus.h_gnt     = w_h_gnt;
    assign bus.c_rvalid  = r_c_rvalid;
    assign bus.h_rvalid  = r_h_rvalid;
    assign bus.c_rdata   = bus.bram_dout;
    assign bus.h_rdata   = bus.bram_dout;
    assign bus.bram_addr = w_bram_addr;
    assign bus.bram_we   = w_bram_we;
    assign bus.bram_din  = w_bram_din;
    assign bus.locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomised and directed bench for bram_port_arbiter against a cycle-level behavioural model.
module tb_bram_port_arbiter;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5000000 ^ (i * 32'h01030507));
    endfunction

    // Simple BRAM: one word per 4-byte address, 1-cycle read latency.
    logic [31:0] bram_mem [64];
    bit          bram_ready = 1'b0;
    always @(posedge clk) begin
        if (!bram_ready) begin
            for (int i = 0; i < 64; i++) bram_mem[i] <= init_word(i);
            bram_ready <= 1'b1;
            bus.bram_dout <= '0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus.bram_we[b]) bram_mem[bus.bram_addr[7:2]][8*b +: 8] <= bus.bram_din[8*b +: 8];
            bus.bram_dout <= bram_mem[bus.bram_addr[7:2]];
        end
    end

    // Behavioural model: who owns the port, how long the host has waited, what reads return.
    int          m_wait   = 0;
    bit          m_locked = 1'b0;
    bit          m_c_rv   = 1'b0;
    bit          m_h_rv   = 1'b0;
    bit          m_cg_last, m_hg_last;
    logic [31:0] m_c_rd, m_h_rd;
    logic [31:0] ref_mem [64];
    bit          ref_ready = 1'b0;

    function automatic void model_grant(output bit cg, output bit hg);
        cg = 1'b0;
        hg = 1'b0;
        if (rst_n === 1'b1) begin
            if (m_locked)                          hg = (bus.h_req === 1'b1);
            else if (bus.h_req && m_wait >= LIMIT) hg = 1'b1;
            else if (bus.c_req)                    cg = 1'b1;
            else if (bus.h_req)                    hg = 1'b1;
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        bit cg, hg;
        if (!ref_ready) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_ready = 1'b1;
        end
        model_grant(cg, hg);
        m_cg_last = cg;
        m_hg_last = hg;
        if (rst_n !== 1'b1) begin
            m_wait = 0; m_locked = 1'b0; m_c_rv = 1'b0; m_h_rv = 1'b0;
        end else begin
            m_c_rv = cg && (bus.c_we == 4'b0);
            m_h_rv = hg && (bus.h_we == 4'b0);
            if (m_c_rv) m_c_rd = ref_mem[bus.c_addr[7:2]];
            if (m_h_rv) m_h_rd = ref_mem[bus.h_addr[7:2]];
            if (cg && bus.c_we != 4'b0) ref_mem[bus.c_addr[7:2]] = merge(ref_mem[bus.c_addr[7:2]], bus.c_wdata, bus.c_we);
            if (hg && bus.h_we != 4'b0) ref_mem[bus.h_addr[7:2]] = merge(ref_mem[bus.h_addr[7:2]], bus.h_wdata, bus.h_we);
            m_wait   = (bus.h_req && !hg) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
            m_locked = m_locked ? bus.h_lock : (hg && bus.h_lock);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit cg, hg;
        if (chk_en) begin
            model_grant(cg, hg);
            chk("c_gnt", bus.c_gnt, cg);
            chk("h_gnt", bus.h_gnt, hg);
            chk("bram_addr", bus.bram_addr, cg ? bus.c_addr : hg ? bus.h_addr : 16'h0);
            chk("bram_we", bus.bram_we, cg ? bus.c_we : hg ? bus.h_we : 4'h0);
            chk("bram_din", bus.bram_din, cg ? bus.c_wdata : hg ? bus.h_wdata : 32'h0);
            chk("c_rvalid", bus.c_rvalid, m_c_rv);
            chk("h_rvalid", bus.h_rvalid, m_h_rv);
            chk("locked", bus.locked, m_locked);
            if (m_c_rv) chk("c_rdata", bus.c_rdata, m_c_rd);
            if (m_h_rv) chk("h_rdata", bus.h_rdata, m_h_rd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_c(input bit req, input logic [3:0] we, input logic [15:0] addr, input logic [31:0] wd);
        bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
    endtask

    task automatic set_h(input bit req, input logic [3:0] we, input logic [15:0] addr, input logic [31:0] wd, input bit lock);
        bus.h_req = req; bus.h_we = we; bus.h_addr = addr; bus.h_wdata = wd; bus.h_lock = lock;
    endtask

    logic [17:0] c_pat, h_pat;
    bit c_pend, h_pend;

    initial begin
        rst_n = 1'b0;
        set_c(1'b1, 4'h0, 16'h0004, 32'h0);
        set_h(1'b1, 4'h0, 16'h0008, 32'h0, 1'b0);
        tick();
        chk_en = 1'b1;

        // Reset held with both requesting.
        repeat (3) begin
            @(negedge clk);
            chk("rst_c_gnt", bus.c_gnt, 1'b0);
            chk("rst_h_gnt", bus.h_gnt, 1'b0);
            chk("rst_bram_we", bus.bram_we, 4'h0);
            tick();
        end
        rst_n = 1'b1;
        set_c(1'b0, 4'h0, 16'h0, 32'h0);
        set_h(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("rst_c_rvalid", bus.c_rvalid, 1'b0);
        chk("rst_h_rvalid", bus.h_rvalid, 1'b0);
        chk("rst_locked", bus.locked, 1'b0);
        tick();

        // CPU read of a known word.
        set_c(1'b1, 4'h0, 16'h0010, 32'h0);
        @(negedge clk);
        chk("rd_c_gnt", bus.c_gnt, 1'b1);
        chk("rd_bram_addr", bus.bram_addr, 16'h0010);
        tick();
        set_c(1'b0, 4'h0, 16'h0, 32'h0);
        @(negedge clk);
        chk("rd_c_rvalid", bus.c_rvalid, 1'b1);
        chk("rd_c_rdata", bus.c_rdata, 32'hDEADBEEF);
        chk("rd_h_rvalid", bus.h_rvalid, 1'b0);
        tick();

        // Continuous contention: host forced through every 9th cycle.
        set_c(1'b1, 4'h0, 16'h0014, 32'h0);
        set_h(1'b1, 4'h0, 16'h0018, 32'h0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            c_pat[i] = bus.c_gnt;
            h_pat[i] = bus.h_gnt;
            tick();
        end
        chk("starve_h_pattern", h_pat, 18'b10_0000_0001_0000_0000);
        chk("starve_c_pattern", c_pat, 18'b01_1111_1110_1111_1111);

        // Let the host starve again, then lock on the forced grant.
        repeat (8) tick();
        set_h(1'b1, 4'h0, 16'h0100, 32'h0, 1'b1);
        @(negedge clk);
        chk("lock_h_gnt", bus.h_gnt, 1'b1);
        chk("lock_c_gnt", bus.c_gnt, 1'b0);
        tick();
        chk("lock_locked", bus.locked, 1'b1);
        for (int i = 1; i < 4; i++) begin
            set_h(1'b1, 4'h0, 16'h0100 + 16'(4 * i), 32'h0, 1'b1);
            @(negedge clk);
            chk("lock_burst_c_gnt", bus.c_gnt, 1'b0);
            chk("lock_burst_h_gnt", bus.h_gnt, 1'b1);
            tick();
        end
        set_h(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("unlock_c_gnt_still_blocked", bus.c_gnt, 1'b0);
        tick();
        @(negedge clk);
        chk("unlock_locked", bus.locked, 1'b0);
        chk("unlock_c_gnt", bus.c_gnt, 1'b1);
        tick();

        // Host partial write produces no read return.
        set_c(1'b0, 4'h0, 16'h0, 32'h0);
        set_h(1'b1, 4'b0011, 16'h0020, 32'h12345678, 1'b0);
        @(negedge clk);
        chk("wr_h_gnt", bus.h_gnt, 1'b1);
        chk("wr_bram_we", bus.bram_we, 4'b0011);
        chk("wr_bram_din", bus.bram_din, 32'h12345678);
        tick();
        set_h(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        @(negedge clk);
        chk("wr_h_rvalid", bus.h_rvalid, 1'b0);
        tick();

        // Reset while locked.
        set_h(1'b1, 4'h0, 16'h0040, 32'h0, 1'b1);
        tick();
        chk("rl_locked", bus.locked, 1'b1);
        set_c(1'b1, 4'h0, 16'h0044, 32'h0);
        @(negedge clk);
        chk("rl_c_blocked", bus.c_gnt, 1'b0);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rl_rst_c_gnt", bus.c_gnt, 1'b0);
        chk("rl_rst_h_gnt", bus.h_gnt, 1'b0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rl_c_gnt_after", bus.c_gnt, 1'b1);
        chk("rl_locked_after", bus.locked, 1'b0);
        chk("rl_h_rvalid_after", bus.h_rvalid, 1'b0);
        tick();
        set_c(1'b0, 4'h0, 16'h0, 32'h0);
        set_h(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        tick();

        // Random traffic; each requester holds its request until granted.
        c_pend = 1'b0;
        h_pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (m_cg_last) c_pend = 1'b0;
            if (m_hg_last) h_pend = 1'b0;
            if (!c_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    set_c(1'b1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                          16'($urandom_range(0, 63) * 4), $urandom);
                    c_pend = 1'b1;
                end else begin
                    bus.c_req = 1'b0;
                end
            end
            if (!h_pend) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.h_req   = 1'b1;
                    bus.h_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                    bus.h_addr  = 16'($urandom_range(0, 63) * 4);
                    bus.h_wdata = $urandom;
                    h_pend = 1'b1;
                end else begin
                    bus.h_req = 1'b0;
                end
            end
            if ($urandom_range(0, 9) == 0) bus.h_lock = ~bus.h_lock;
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end

        rst_n = 1'b1;
        set_c(1'b0, 4'h0, 16'h0, 32'h0);
        set_h(1'b0, 4'h0, 16'h0, 32'h0, 1'b0);
        repeat (3) tick();
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one synchronous BRAM port (1-cycle read latency) between two requesters: the CPU data-memory interface (requester C) and the UART host debug/loader engine (requester H). Fixed CPU priority with a host starvation guard, plus a host lock so the host can hold the port for multi-word bursts. Sits between the CPU load/store path, the host memory-access engine and the BRAM data port.

## Interface
- ADDR_WIDTH, 16, byte address width on all ports
- DATA_WIDTH, 32, data word width; write enable is DATA_WIDTH/8 bits
- STARVE_LIMIT, 8, consecutive host wait cycles before host is forced ahead (>=1)

Reset rst_n, synchronous, active-low; clock clk.
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- c_req  in  1  CPU access request
- c_we  in  4  CPU byte write enables; 0 = read
- c_addr  in  ADDR_WIDTH  CPU address
- c_wdata  in  DATA_WIDTH  CPU write data
- c_gnt  out  1  CPU access issued this cycle (combinational)
- c_rvalid  out  1  CPU read data valid (registered)
- c_rdata  out  DATA_WIDTH  CPU read data
- h_req, h_we, h_addr, h_wdata  in  1/4/ADDR_WIDTH/DATA_WIDTH  host request, same meaning as CPU
- h_lock  in  1  host requests exclusive ownership while high
- h_gnt, h_rvalid, h_rdata  out  1/1/DATA_WIDTH  host grant, read valid, read data
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_we  out  4  BRAM byte write enables
- bram_din  out  DATA_WIDTH  BRAM write data
- bram_dout  in  DATA_WIDTH  BRAM read data (valid 1 cycle after address)
- locked  out  1  high while in LOCKED state

## Operation
- States: OPEN, LOCKED. Reset -> OPEN.
- Grant (combinational, at most one per cycle, never both):
  - OPEN: if h_req and starve_cnt == STARVE_LIMIT -> h_gnt; else if c_req -> c_gnt; else if h_req -> h_gnt.
  - LOCKED: h_gnt = h_req; c_gnt = 0 always.
- BRAM drive: bram_addr/bram_we/bram_din from granted requester; no grant -> bram_we = 0, bram_addr = 0, bram_din = 0.
- OPEN -> LOCKED at edge where h_gnt && h_lock. LOCKED -> OPEN at any edge where h_lock == 0 (independent of h_req). h_lock with no host grant has no effect in OPEN.
- starve_cnt (width clog2(STARVE_LIMIT+1)): +1 at edge where h_req && !h_gnt, saturating at STARVE_LIMIT; cleared at edge where h_gnt or !h_req.
- Read return: x_rvalid <= x_gnt && (x_we == 0). Writes never produce rvalid. c_rdata and h_rdata both wire to bram_dout; meaningful only when matching rvalid high.
- Requesters hold req/addr/we/wdata stable until grant; a non-granted request is not queued inside the block.

## Timing
- Reset (rst_n low at edge): state OPEN, starve_cnt 0, c_rvalid 0, h_rvalid 0, locked 0. While rst_n low, c_gnt = h_gnt = 0 and bram_we = 0 (reset gates grants combinationally).
- Grant latency 0 cycles; read data latency 1 cycle after grant cycle; back-to-back grants every cycle supported, rvalid then high every cycle.
- Switching owner (C->H or H->C) costs no dead cycle; rvalid of previous owner and new grant may coincide.
- Reset during LOCKED: returns to OPEN; outstanding rvalid dropped.
- Simultaneous c_req and h_req with starve_cnt < STARVE_LIMIT: CPU wins, starve_cnt increments.
- After forced host grant, starve_cnt clears; CPU wins next contended cycle.
- locked is the registered state bit; goes high the cycle after the locking grant.

## Test plan
- Reset: hold rst_n low 3 cycles with c_req=h_req=1 -> c_gnt=h_gnt=0, bram_we=0, rvalids 0, locked 0.
- CPU read: c_req=1, c_we=0, c_addr=0x0010, bram_dout=0xDEADBEEF next cycle -> c_gnt same cycle, bram_addr=0x0010, c_rvalid=1 with c_rdata=0xDEADBEEF one cycle later; h_rvalid stays 0.
- Contention/starvation: c_req and h_req held high continuously, STARVE_LIMIT=8 -> c_gnt for 8 cycles, h_gnt on 9th, then c_gnt resumes; pattern repeats every 9 cycles.
- Host lock burst: h_req=1,h_lock=1 with c_req=1 and starve_cnt forced to limit -> host granted, locked=1 next cycle, c_gnt=0 for 4 host reads at 0x0100..0x010C; drop h_lock -> locked=0 next cycle, c_gnt=1 immediately after.
- Write no rvalid: h_we=4'b0011, h_addr=0x0020, h_wdata=0x12345678 -> bram_we=0011, bram_din=0x12345678, h_rvalid stays 0.
- Reset mid-lock: enter LOCKED, assert rst_n low one cycle -> locked=0, starve_cnt=0, CPU granted on first cycle after release with both requesting.
